// File: rtl/netwalk_dataplane_output_merger.sv
// NetWalk dataplane output stage. Merges N header channels through per-channel
// FIFOs into one valid/ready stream, with fixed-priority or round-robin arbitration.

module netwalk_dataplane_output_merger_fifo #(
    parameter int ENTRY_W    = 613,
    parameter int DEPTH_LOG2 = 2,
    parameter int DCW        = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic               drop_clear,
    input  logic [ENTRY_W-1:0] wdata,
    output logic [ENTRY_W-1:0] rdata,
    output logic               empty,
    output logic               full,
    output logic [DCW-1:0]     drop_count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [ENTRY_W-1:0]  mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic                do_push, do_drop, do_pop;

    // A push into a full FIFO is dropped even when a pop frees a slot on the same edge.
    assign do_push = push & ~full;
    assign do_drop = push & full;
    assign do_pop  = pop & ~empty;
    assign wr_nxt  = wr_ptr + (DEPTH_LOG2+1)'(do_push);
    assign rd_nxt  = rd_ptr + (DEPTH_LOG2+1)'(do_pop);
    assign rdata   = mem[rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            empty  <= (wr_nxt == rd_nxt);
            full   <= ((wr_nxt ^ rd_nxt) == {1'b1, {DEPTH_LOG2{1'b0}}});
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      drop_count <= '0;
        else if (drop_clear)             drop_count <= '0;
        else if (do_drop && !(&drop_count)) drop_count <= drop_count + 1'b1;
    end
endmodule

module netwalk_dataplane_output_merger #(
    parameter int NUM_CH            = 2,
    parameter int CH_SEL_WIDTH      = 1,
    parameter int MISS_CH           = 1,
    parameter int DPL_PKT_BIT_WIDTH = 608,
    parameter int OF_FLOW_TAG_WIDTH = 5,
    parameter int FIFO_DEPTH_LOG2   = 2,
    parameter int DROP_COUNTER_SIZE = 32
) (
    input  logic                                  dpl_clk,
    input  logic                                  dpl_reset,
    input  logic                                  dpl_arb_mode,
    input  logic [NUM_CH*DPL_PKT_BIT_WIDTH-1:0]   dpl_ch_pkt_header,
    input  logic [NUM_CH*OF_FLOW_TAG_WIDTH-1:0]   dpl_ch_flow_tag,
    input  logic [NUM_CH-1:0]                     dpl_ch_valid,
    output logic [DPL_PKT_BIT_WIDTH-1:0]          dpl_pkt_header_out,
    output logic [OF_FLOW_TAG_WIDTH-1:0]          dpl_flow_tag,
    output logic [CH_SEL_WIDTH-1:0]               dpl_src_ch,
    output logic                                  dpl_of_table_missed,
    output logic                                  dpl_pkt_header_out_enable,
    input  logic                                  dpl_pkt_header_out_ready,
    output logic [NUM_CH-1:0]                     dpl_fifo_full,
    output logic [NUM_CH*DROP_COUNTER_SIZE-1:0]   dpl_drop_count,
    input  logic                                  dpl_drop_clear
);
    localparam int ENTRY_W = DPL_PKT_BIT_WIDTH + OF_FLOW_TAG_WIDTH;

    logic [NUM_CH-1:0][ENTRY_W-1:0] fifo_rdata;
    logic [NUM_CH-1:0]              fifo_empty;
    logic [NUM_CH-1:0]              pop;
    logic [CH_SEL_WIDTH-1:0]        grant, rr_ptr;
    logic                           grant_vld, load;
    logic [ENTRY_W-1:0]             grant_data;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        netwalk_dataplane_output_merger_fifo #(
            .ENTRY_W    (ENTRY_W),
            .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
            .DCW        (DROP_COUNTER_SIZE)
        ) u_fifo (
            .clk        (dpl_clk),
            .rst_n      (dpl_reset),
            .push       (dpl_ch_valid[g]),
            .pop        (pop[g]),
            .drop_clear (dpl_drop_clear),
            .wdata      ({dpl_ch_pkt_header[g*DPL_PKT_BIT_WIDTH +: DPL_PKT_BIT_WIDTH],
                          dpl_ch_flow_tag[g*OF_FLOW_TAG_WIDTH +: OF_FLOW_TAG_WIDTH]}),
            .rdata      (fifo_rdata[g]),
            .empty      (fifo_empty[g]),
            .full       (dpl_fifo_full[g]),
            .drop_count (dpl_drop_count[g*DROP_COUNTER_SIZE +: DROP_COUNTER_SIZE])
        );
    end

    // Descending scans so the last hit (lowest index / nearest after ptr) wins.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        if (!dpl_arb_mode) begin
            for (int i = NUM_CH-1; i >= 0; i--) begin
                if (!fifo_empty[i]) begin
                    grant_vld = 1'b1;
                    grant     = CH_SEL_WIDTH'(i);
                end
            end
        end else begin
            for (int k = NUM_CH; k >= 1; k--) begin
                if (!fifo_empty[(int'(rr_ptr) + k) % NUM_CH]) begin
                    grant_vld = 1'b1;
                    grant     = CH_SEL_WIDTH'((int'(rr_ptr) + k) % NUM_CH);
                end
            end
        end
    end

    assign load       = (!dpl_pkt_header_out_enable || dpl_pkt_header_out_ready) && grant_vld;
    assign grant_data = fifo_rdata[grant];

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_CH; i++) pop[i] = load && (grant == CH_SEL_WIDTH'(i));
    end

    always_ff @(posedge dpl_clk or negedge dpl_reset) begin
        if (!dpl_reset) begin
            dpl_pkt_header_out        <= '0;
            dpl_flow_tag              <= '0;
            dpl_src_ch                <= '0;
            dpl_of_table_missed       <= 1'b0;
            dpl_pkt_header_out_enable <= 1'b0;
            rr_ptr                    <= CH_SEL_WIDTH'(NUM_CH-1);
        end else if (load) begin
            {dpl_pkt_header_out, dpl_flow_tag} <= grant_data;
            dpl_src_ch                <= grant;
            dpl_of_table_missed       <= (grant == CH_SEL_WIDTH'(MISS_CH));
            dpl_pkt_header_out_enable <= 1'b1;
            rr_ptr                    <= grant;
        end else if (dpl_pkt_header_out_enable && dpl_pkt_header_out_ready) begin
            // Accepted with nothing queued: data/tag/src keep their last values.
            dpl_pkt_header_out_enable <= 1'b0;
            dpl_of_table_missed       <= 1'b0;
        end
    end
endmodule

// File: tb/tb_netwalk_dataplane_output_merger.sv
// Scoreboard bench for the NetWalk output merger: per-channel expected queues
// filled at push time, compared against packets accepted on the output handshake.

module tb_netwalk_dataplane_output_merger;
    localparam int NCH = 2;
    localparam int HW  = 608;
    localparam int TW  = 5;
    localparam int DCW = 4;

    logic              clk = 1'b0;
    logic              rst_n, arb_mode, ready, drop_clear;
    logic [NCH*HW-1:0] ch_hdr;
    logic [NCH*TW-1:0] ch_tag;
    logic [NCH-1:0]    ch_valid;
    logic [HW-1:0]     hdr_out;
    logic [TW-1:0]     tag_out;
    logic              src_out, missed, en;
    logic [NCH-1:0]    fifo_full;
    logic [NCH*DCW-1:0] drop_cnt;

    always #5 clk = ~clk;

    netwalk_dataplane_output_merger #(
        .NUM_CH(NCH), .CH_SEL_WIDTH(1), .MISS_CH(1), .DPL_PKT_BIT_WIDTH(HW),
        .OF_FLOW_TAG_WIDTH(TW), .FIFO_DEPTH_LOG2(2), .DROP_COUNTER_SIZE(DCW)
    ) dut (
        .dpl_clk(clk), .dpl_reset(rst_n), .dpl_arb_mode(arb_mode),
        .dpl_ch_pkt_header(ch_hdr), .dpl_ch_flow_tag(ch_tag), .dpl_ch_valid(ch_valid),
        .dpl_pkt_header_out(hdr_out), .dpl_flow_tag(tag_out), .dpl_src_ch(src_out),
        .dpl_of_table_missed(missed), .dpl_pkt_header_out_enable(en),
        .dpl_pkt_header_out_ready(ready), .dpl_fifo_full(fifo_full),
        .dpl_drop_count(drop_cnt), .dpl_drop_clear(drop_clear)
    );

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [HW-1:0] hdr;
    } pkt_t;

    typedef struct {
        int   src;
        logic missed;
        pkt_t pkt;
        int   cyc;
    } rx_t;

    pkt_t exp0_q[$];
    pkt_t exp1_q[$];
    rx_t  rx_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Every packet the downstream side accepts, in acceptance order.
    always @(negedge clk) begin
        if (rst_n && en && ready)
            rx_q.push_back('{int'(src_out), missed, {tag_out, hdr_out}, cyc});
    end

    function automatic pkt_t exp_pop(input int src);
        pkt_t p;
        p = 'x;
        if (src == 0 && exp0_q.size() > 0) p = exp0_q.pop_front();
        if (src == 1 && exp1_q.size() > 0) p = exp1_q.pop_front();
        return p;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; ch_valid = '0; ready = 1'b0; drop_clear = 1'b0; arb_mode = 1'b0;
        ch_hdr = '0; ch_tag = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp0_q.delete(); exp1_q.delete(); rx_q.delete();
    endtask

    // One push cycle; rec selects which channels are expected to be accepted.
    task automatic drive(input logic [1:0] v, input logic [TW-1:0] t0, input logic [TW-1:0] t1,
                         input logic [1:0] rec);
        pkt_t p0, p1;
        p0.tag = t0; p1.tag = t1;
        for (int w = 0; w < HW/32; w++) begin
            p0.hdr[w*32 +: 32] = $urandom;
            p1.hdr[w*32 +: 32] = $urandom;
        end
        ch_hdr = {p1.hdr, p0.hdr};
        ch_tag = {p1.tag, p0.tag};
        ch_valid = v;
        if (rec[0]) exp0_q.push_back(p0);
        if (rec[1]) exp1_q.push_back(p1);
        @(posedge clk);
        #1 ch_valid = '0;
    endtask

    task automatic wait_rx(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (rx_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ch_valid = '0; ready = 1'b0; drop_clear = 1'b0; arb_mode = 1'b0;
        ch_hdr = '0; ch_tag = '0;
        #1;
        n_checks++;
        if ({en, missed, src_out, tag_out, fifo_full} !== '0)
            $display("FAIL reset_ctrl: got %0h want 0", {en, missed, src_out, tag_out, fifo_full});
        else n_pass++;
        n_checks++;
        if (hdr_out !== '0) $display("FAIL reset_hdr: got %0h want 0", hdr_out);
        else n_pass++;
        n_checks++;
        if (drop_cnt !== '0) $display("FAIL reset_drop: got %0h want 0", drop_cnt);
        else n_pass++;
    endtask

    task automatic test_latency();
        pkt_t e;
        do_reset();
        ready = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        drive(2'b01, 5'h03, 5'h00, 2'b01);
        @(negedge clk);
        n_checks++;
        if (en !== 1'b0) $display("FAIL lat_n1_en: got %b want 0", en); else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({en, tag_out, src_out, missed} !== {1'b1, 5'h03, 1'b0, 1'b0})
            $display("FAIL lat_n2: got en=%b tag=%0h src=%0d miss=%b want 1,3,0,0", en, tag_out, src_out, missed);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (en !== 1'b0) $display("FAIL lat_n3_en: got %b want 0", en); else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (rx_q.size() != 1) $display("FAIL lat_count: got %0d want 1", rx_q.size());
        else begin
            e = exp_pop(0);
            if (rx_q[0].pkt !== e) $display("FAIL lat_pkt: got %0h want %0h", rx_q[0].pkt, e);
            else n_pass++;
        end
    endtask

    task automatic test_miss_collision();
        bit ok;
        pkt_t e;
        do_reset();
        ready = 1'b1;
        drive(2'b11, 5'h07, 5'h09, 2'b11);
        wait_rx(2, ok);
        n_checks++;
        if (!ok) $display("FAIL coll_timeout: got %0d want 2 packets", rx_q.size());
        else begin
            n_pass++;
            for (int i = 0; i < 2; i++) begin
                e = exp_pop(i);
                n_checks++;
                if (rx_q[i].src !== i || rx_q[i].missed !== (i == 1) || rx_q[i].pkt !== e)
                    $display("FAIL coll[%0d]: got src=%0d miss=%b tag=%0h want src=%0d miss=%b tag=%0h",
                             i, rx_q[i].src, rx_q[i].missed, rx_q[i].pkt.tag, i, (i == 1), e.tag);
                else n_pass++;
            end
            n_checks++;
            if (rx_q[1].cyc != rx_q[0].cyc + 1)
                $display("FAIL coll_b2b: got gap %0d want 1", rx_q[1].cyc - rx_q[0].cyc);
            else n_pass++;
        end
    endtask

    task automatic test_arb(input logic mode);
        bit ok;
        int want_src;
        pkt_t e;
        do_reset();
        arb_mode = mode;
        for (int i = 0; i < 4; i++) drive(2'b11, TW'(i), TW'(16 + i), 2'b11);
        ready = 1'b1;
        wait_rx(8, ok);
        n_checks++;
        if (!ok) $display("FAIL arb%0d_timeout: got %0d want 8 packets", mode, rx_q.size());
        else begin
            n_pass++;
            for (int i = 0; i < 8; i++) begin
                want_src = mode ? (i % 2) : (i < 4 ? 0 : 1);
                e = exp_pop(want_src);
                n_checks++;
                if (rx_q[i].src !== want_src || rx_q[i].pkt !== e || rx_q[i].cyc != rx_q[0].cyc + i)
                    $display("FAIL arb%0d[%0d]: got src=%0d tag=%0h cyc+%0d want src=%0d tag=%0h cyc+%0d",
                             mode, i, rx_q[i].src, rx_q[i].pkt.tag, rx_q[i].cyc - rx_q[0].cyc,
                             want_src, e.tag, i);
                else n_pass++;
            end
        end
    endtask

    task automatic test_full_drop();
        bit ok;
        pkt_t e;
        do_reset();
        drive(2'b01, 5'h01, 5'h00, 2'b01);
        for (int i = 1; i <= 6; i++) begin
            drive(2'b10, 5'h00, TW'(i), (i <= 4) ? 2'b10 : 2'b00);
            if (i == 3 || i == 4) begin
                n_checks++;
                if (fifo_full[1] !== (i == 4))
                    $display("FAIL full_after_%0d: got %b want %b", i, fifo_full[1], (i == 4));
                else n_pass++;
            end
        end
        repeat (3) begin @(posedge clk); #1; end
        n_checks++;
        if (drop_cnt[DCW +: DCW] !== DCW'(2)) $display("FAIL drop_cnt: got %0d want 2", drop_cnt[DCW +: DCW]);
        else n_pass++;
        n_checks++;
        if ({en, src_out, tag_out} !== {1'b1, 1'b0, 5'h01})
            $display("FAIL held: got en=%b src=%0d tag=%0h want 1,0,1", en, src_out, tag_out);
        else n_pass++;
        ready = 1'b1;
        wait_rx(5, ok);
        n_checks++;
        if (!ok) $display("FAIL drain_timeout: got %0d want 5 packets", rx_q.size());
        else begin
            n_pass++;
            for (int i = 0; i < 5; i++) begin
                e = exp_pop(i == 0 ? 0 : 1);
                n_checks++;
                if (rx_q[i].src !== (i == 0 ? 0 : 1) || rx_q[i].pkt !== e)
                    $display("FAIL drain[%0d]: got src=%0d tag=%0h want src=%0d tag=%0h",
                             i, rx_q[i].src, rx_q[i].pkt.tag, (i == 0 ? 0 : 1), e.tag);
                else n_pass++;
            end
        end
        n_checks++;
        if ({fifo_full[1], drop_cnt[DCW +: DCW]} !== {1'b0, DCW'(2)})
            $display("FAIL post_drain: got full=%b cnt=%0d want 0,2", fifo_full[1], drop_cnt[DCW +: DCW]);
        else n_pass++;
    endtask

    task automatic test_drop_sat();
        bit ok;
        pkt_t e;
        do_reset();
        drive(2'b01, 5'h0a, 5'h00, 2'b01);
        for (int i = 0; i < 4; i++) drive(2'b10, 5'h00, TW'(i + 1), 2'b10);
        for (int i = 0; i < 15; i++) drive(2'b10, 5'h00, 5'h1f, 2'b00);
        n_checks++;
        if (drop_cnt[DCW +: DCW] !== '1) $display("FAIL sat_reach: got %0d want 15", drop_cnt[DCW +: DCW]);
        else n_pass++;
        drive(2'b10, 5'h00, 5'h1f, 2'b00);
        n_checks++;
        if (drop_cnt[DCW +: DCW] !== '1) $display("FAIL sat_hold: got %0d want 15", drop_cnt[DCW +: DCW]);
        else n_pass++;
        drop_clear = 1'b1;
        drive(2'b10, 5'h00, 5'h1f, 2'b00);
        drop_clear = 1'b0;
        n_checks++;
        if (drop_cnt[DCW +: DCW] !== '0) $display("FAIL clear_wins: got %0d want 0", drop_cnt[DCW +: DCW]);
        else n_pass++;
        // Full FIFO popped on the same edge as a push: the push is still dropped.
        ready = 1'b1;
        drive(2'b10, 5'h00, 5'h1e, 2'b00);
        n_checks++;
        if (drop_cnt[DCW +: DCW] !== DCW'(1)) $display("FAIL drop_on_pop: got %0d want 1", drop_cnt[DCW +: DCW]);
        else n_pass++;
        wait_rx(5, ok);
        repeat (3) begin @(posedge clk); #1; end
        n_checks++;
        if (!ok || rx_q.size() != 5) $display("FAIL sat_drain: got %0d want 5 packets", rx_q.size());
        else begin
            n_pass++;
            for (int i = 0; i < 5; i++) begin
                e = exp_pop(i == 0 ? 0 : 1);
                n_checks++;
                if (rx_q[i].src !== (i == 0 ? 0 : 1) || rx_q[i].pkt !== e)
                    $display("FAIL sat_drain[%0d]: got src=%0d tag=%0h want src=%0d tag=%0h",
                             i, rx_q[i].src, rx_q[i].pkt.tag, (i == 0 ? 0 : 1), e.tag);
                else n_pass++;
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(2'b01, 5'h11, 5'h00, 2'b01);
        drive(2'b10, 5'h00, 5'h12, 2'b10);
        drive(2'b10, 5'h00, 5'h13, 2'b10);
        n_checks++;
        if (en !== 1'b1) $display("FAIL arst_pre_en: got %b want 1", en); else n_pass++;
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({en, missed, src_out, tag_out, fifo_full} !== '0 || hdr_out !== '0)
            $display("FAIL arst_out: got en=%b tag=%0h src=%0d want all 0", en, tag_out, src_out);
        else n_pass++;
        exp0_q.delete(); exp1_q.delete(); rx_q.delete();
        #3 rst_n = 1'b1;
        ready = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        n_checks++;
        if (rx_q.size() != 0 || en !== 1'b0)
            $display("FAIL arst_stale: got %0d packets en=%b want 0,0", rx_q.size(), en);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_miss_collision();
        test_arb(1'b1);
        test_arb(1'b0);
        test_full_drop();
        test_drop_sat();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/netwalk_dataplane_output_merger.md
Name: netwalk_dataplane_output_merger

Overview:
- Parametrised N-channel output stage for the NetWalk dataplane.
- Merges the matched-flow path, the table-miss path and any further channels into one packet-header output stream.
- Replaces the combinational priority mux, under which a miss coinciding with a match was lost. Each channel now has its own small FIFO, with fixed-priority or round-robin arbitration.
- Adds a valid/ready output handshake and per-channel saturating drop counters.

Parameters:
NUM_CH, 2, number of input channels (ch0 = matched path, ch1 = miss path by convention)
CH_SEL_WIDTH, 1, width of channel index; NUM_CH <= 2**CH_SEL_WIDTH
MISS_CH, 1, channel index whose packets raise dpl_of_table_missed
DPL_PKT_BIT_WIDTH, 608, packet header width
OF_FLOW_TAG_WIDTH, 5, flow tag width
FIFO_DEPTH_LOG2, 2, per-channel FIFO depth = 2**FIFO_DEPTH_LOG2 entries
DROP_COUNTER_SIZE, 32, per-channel drop counter width

Ports:
dpl_clk  in  1  clock, all logic on rising edge
dpl_reset  in  1  asynchronous active-low reset
dpl_arb_mode  in  1  0 = fixed priority (lowest index wins), 1 = round-robin
dpl_ch_pkt_header  in  NUM_CH*DPL_PKT_BIT_WIDTH  per-channel header, ch i at slice i
dpl_ch_flow_tag  in  NUM_CH*OF_FLOW_TAG_WIDTH  per-channel flow tag
dpl_ch_valid  in  NUM_CH  per-channel single-cycle push strobe (no backpressure upstream)
dpl_pkt_header_out  out  DPL_PKT_BIT_WIDTH  merged header
dpl_flow_tag  out  OF_FLOW_TAG_WIDTH  tag of current output
dpl_src_ch  out  CH_SEL_WIDTH  source channel of current output
dpl_of_table_missed  out  1  high with enable when dpl_src_ch == MISS_CH
dpl_pkt_header_out_enable  out  1  output valid
dpl_pkt_header_out_ready  in  1  downstream accept
dpl_fifo_full  out  NUM_CH  per-channel FIFO full flag (registered)
dpl_drop_count  out  NUM_CH*DROP_COUNTER_SIZE  per-channel dropped-push count
dpl_drop_clear  in  1  synchronous clear of all drop counters

Behaviour:
- Reset (dpl_reset=0, async): all FIFOs empty; every output 0; drop counters 0; RR pointer = NUM_CH-1, so ch0 is first under RR. Reset mid-transfer discards all buffered and in-flight packets.
- Push: dpl_ch_valid[i]=1 with FIFO i not full at the start of the cycle writes {header,tag}. If FIFO i is full, the push is dropped even if a pop of FIFO i occurs in the same cycle, and drop_count[i] increments.
- Drop counters saturate at all-ones. dpl_drop_clear wins over a simultaneous increment (result 0).
- Output register loads when (!enable) or (enable & ready) and at least one FIFO is non-empty. The granted FIFO pops on the same edge.
- enable & ready with all FIFOs empty: enable drops to 0 next cycle. Data/tag/src hold their last values.
- enable & !ready: all outputs held stable; no pops.
- Latency: a push in cycle N into an empty system with an idle output gives enable=1 in cycle N+2. Sustained throughput is 1 packet/cycle while ready=1.
- Fixed priority: grant the lowest-index non-empty FIFO.
- Round-robin: grant the first non-empty FIFO searching from ptr+1 upward with modulo NUM_CH wrap. ptr is set to the granted index only on a grant.
- A dpl_arb_mode change takes effect at the next arbitration. ptr is retained across mode changes.
- FIFO pointers are FIFO_DEPTH_LOG2+1 bits with wrap-bit compare. Full and empty are exact at 2**FIFO_DEPTH_LOG2 entries.
- Simultaneous push and pop on a non-full FIFO: both occur and the occupancy is unchanged. On an empty FIFO, a push is not visible to the arbiter until the next cycle (no bypass).
- dpl_of_table_missed = enable & (dpl_src_ch == MISS_CH), registered with the output.
- Per-channel order is preserved. There is no cross-channel ordering guarantee.

Test Plan:
1. Reset, then a ch0 push (tag 5'h03) at cycle 10 with ready=1 -> enable=1 at cycle 12, tag=3, src=0, missed=0; enable=0 at cycle 13.
2. ch0 and ch1 push in the same cycle, fixed mode, ready=1 -> ch0 output first, ch1 next cycle with missed=1; nothing lost (old-mux bug case).
3. RR mode, both FIFOs kept non-empty, ready=1 for 8 cycles -> src sequence 0,1,0,1,0,1,0,1. Same stimulus in fixed mode -> ch0 drains before any ch1 output.
4. ready=0, 6 pushes on ch1 (depth 4) -> fifo_full[1]=1 after the 4th push; drop_count[1]=2; output held on the first packet. Release ready -> 4 packets out in order; counter stays 2.
5. Drop counter at all-ones with a further drop -> stays all-ones. drop_clear in the same cycle as a drop -> 0.
6. Assert dpl_reset=0 asynchronously with enable=1 and FIFOs partially full -> outputs 0 immediately. After release, no stale packet appears without a new push.
